gray_ptr_ctrl: RTL
==================

GRAY_PTR_CTRL -- requirements
Module: gray_ptr_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8: FIFO address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits (wrap bit).
REQ-002 Parameter MODE, default PTR_WR: PTR_WR = write-side pointer with full flag; PTR_RD = read-side pointer with empty flag.
REQ-003 Parameter SYNC_STAGES, default 2 (legal 2..4): number of flops synchronising the remote pointer.
REQ-004 Parameter ALMOST_LVL, default 2**ADDR_W-2: threshold for the almost output.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-007 inc  in  1  request to advance the local pointer by one entry.
REQ-008 remote_ptr  in  ADDR_W+1  Gray-coded pointer of the opposite FIFO side, asynchronous to clk.
REQ-009 ptr  out  ADDR_W+1  registered Gray-coded local pointer, exported to the opposite side.
REQ-010 addr  out  ADDR_W  registered binary RAM address (low ADDR_W bits of the binary pointer).
REQ-011 flag  out  1  registered; full when MODE=PTR_WR, empty when MODE=PTR_RD.
REQ-012 almost  out  1  registered; almost-full (PTR_WR) or almost-empty (PTR_RD).
REQ-013 level  out  ADDR_W+1  registered occupancy estimate, 0..2**ADDR_W.

Function
REQ-014 Accepted increment = inc AND NOT flag; a request while flag=1 is dropped with no state change.
REQ-015 bin_next = bin + accepted increment, modulo 2**(ADDR_W+1); gray_next = bin_next XOR (bin_next >> 1).
REQ-016 bin, ptr and addr register bin_next/gray_next on the same edge the increment is accepted (latency 1 edge, no bubble; back-to-back incs advance every cycle).
REQ-017 Wrap: bin 2**(ADDR_W+1)-1 -> 0; ptr changes exactly one bit on every advance, including the wrap.
REQ-018 remote_ptr passes through SYNC_STAGES flops (rsync); no other logic samples remote_ptr.
REQ-019 PTR_WR: flag_next = (gray_next == {~rsync[ADDR_W:ADDR_W-1], rsync[ADDR_W-2:0]}).
REQ-020 PTR_RD: flag_next = (gray_next == rsync).
REQ-021 flag is registered from flag_next, so the edge accepting the last free/filled entry also asserts flag.
REQ-022 A remote_ptr change reaches flag, level and almost within SYNC_STAGES+1 rising edges.
REQ-023 level_next = bin_next - gray2bin(rsync) (PTR_WR) or gray2bin(rsync) - bin_next (PTR_RD), modulo 2**(ADDR_W+1).
REQ-024 almost_next = (level_next >= ALMOST_LVL) for PTR_WR; (level_next <= ALMOST_LVL) for PTR_RD.
REQ-025 Simultaneous accepted inc and rsync update: both take effect in the same cycle's flag/level computation.
REQ-026 The block never reports level > 2**ADDR_W while remote_ptr is a legal Gray pointer.

Reset
REQ-027 While reset_n=0 at an edge: bin=0, ptr=0, addr=0, all rsync stages=0, level=0.
REQ-028 Reset values: flag=0, almost=0 for PTR_WR; flag=1, almost=1 for PTR_RD.
REQ-029 Reset mid-operation discards all pointer state; inc is ignored on the reset edge.

Structure
REQ-030 Package gray_ptr_pkg holds typedef enum ptr_mode_e {PTR_WR, PTR_RD} and functions bin2gray and gray2bin, parameterised by width.
REQ-031 Sub-module gray_sync (parameters WIDTH, STAGES; ports clk, reset_n, d, q) implements the synchroniser chain.
REQ-032 All outputs are driven directly from flops; no combinational path from inc or remote_ptr to any output.

Verification (ADDR_W=3, SYNC_STAGES=2, ALMOST_LVL=6)
REQ-033 PTR_WR, remote_ptr=0, 8 consecutive incs -> flag=1 on the 8th edge, ptr=4'b1100, addr=0, level=8; 9th inc -> no change.
REQ-034 PTR_RD after reset -> flag=1, almost=1; remote_ptr=4'b0010 -> flag=0, level=3 within 3 edges; 3 incs -> flag=1 on 3rd edge, ptr=4'b0010.
REQ-035 PTR_WR, 16 incs with remote_ptr tracking ptr -> each ptr step differs in one bit; final ptr=4'b0000, flag never asserts.
REQ-036 PTR_WR at level 7, inc together with remote_ptr advancing by 1 -> level remains 7 after sync, flag=0; almost=1 throughout.
REQ-037 PTR_WR full (level 8), reset_n=0 for 1 edge with inc=1 -> ptr=0, addr=0, flag=0, level=0 next cycle.
REQ-038 PTR_WR, fill to level 6 -> almost=1 on the edge accepting the 6th inc; level 5 -> almost=0.

Source files
------------

// File: rtl/gray_ptr_pkg.sv
// Shared types and Gray/binary helpers for the FIFO pointer blocks.
// Helpers work on a wide vector; callers zero-extend and truncate.
package gray_ptr_pkg;

    typedef enum logic {
        PTR_WR = 1'b0,
        PTR_RD = 1'b1
    } ptr_mode_e;

    localparam int GRAY_MAX_W = 16;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(
        input logic [GRAY_MAX_W-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(
        input logic [GRAY_MAX_W-1:0] g
    );
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        for (int i = 1; i < GRAY_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Only one bit changes per remote step, so each stage captures a valid code.
module gray_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg [STAGES];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/gray_ptr_ctrl.sv
// One side of an async FIFO: local Gray pointer, RAM address,
// full/empty and almost flags, and an occupancy estimate.
module gray_ptr_ctrl
    import gray_ptr_pkg::*;
#(
    parameter int        ADDR_W      = 8,
    parameter ptr_mode_e MODE        = PTR_WR,
    parameter int        SYNC_STAGES = 2,
    parameter int        ALMOST_LVL  = 2**ADDR_W - 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inc,
    input  logic [ADDR_W:0]   remote_ptr,
    output logic [ADDR_W:0]   ptr,
    output logic [ADDR_W-1:0] addr,
    output logic              flag,
    output logic              almost,
    output logic [ADDR_W:0]   level
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] ALMOST_THR = PW'(ALMOST_LVL);
    localparam logic FLAG_RST = (MODE == PTR_RD);

    logic [PW-1:0] bin;
    logic [PW-1:0] bin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] rsync;
    logic [PW-1:0] rbin;
    logic [PW-1:0] full_cmp;
    logic [PW-1:0] level_next;
    logic          acc;
    logic          flag_next;
    logic          almost_next;

    gray_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (remote_ptr),
        .q       (rsync)
    );

    // Full: remote is exactly one lap behind, i.e. top two Gray bits inverted.
    always_comb begin
        acc         = inc & ~flag;
        bin_next    = bin + PW'(acc);
        gray_next   = PW'(bin2gray(GRAY_MAX_W'(bin_next)));
        rbin        = PW'(gray2bin(GRAY_MAX_W'(rsync)));
        full_cmp    = {~rsync[ADDR_W:ADDR_W-1], rsync[ADDR_W-2:0]};
        level_next  = '0;
        flag_next   = 1'b0;
        almost_next = 1'b0;
        if (MODE == PTR_WR) begin
            level_next  = bin_next - rbin;
            flag_next   = (gray_next == full_cmp);
            almost_next = (level_next >= ALMOST_THR);
        end else begin
            level_next  = rbin - bin_next;
            flag_next   = (gray_next == rsync);
            almost_next = (level_next <= ALMOST_THR);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bin    <= '0;
            ptr    <= '0;
            addr   <= '0;
            level  <= '0;
            flag   <= FLAG_RST;
            almost <= FLAG_RST;
        end else begin
            bin    <= bin_next;
            ptr    <= gray_next;
            addr   <= bin_next[ADDR_W-1:0];
            level  <= level_next;
            flag   <= flag_next;
            almost <= almost_next;
        end
    end

endmodule
